mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port between two requesters: instruction fetch (IF, which feeds the IF/ID pipeline register) and the MEM stage (loads/stores).
- Serialises each 1/2/4-byte access into per-byte RAM cycles, assembles read data little-endian and returns a one-cycle done pulse.
- Honours the global rdy freeze and the branch flush (jump_or_not).

Parameters:
ADDR_W  32  address width of requesters and RAM port
DATA_W  32  requester data width; always 4 bytes

Ports:
clk          in   1       clock; all logic on posedge
rst_n        in   1       synchronous reset, active-low
rdy          in   1       global ready; low freezes the block
jump_or_not  in   1       branch flush; aborts or blocks IF traffic
if_req       in   1       IF fetch request; held until if_done
if_addr      in   ADDR_W  fetch address
if_inst      out  DATA_W  fetched word; valid when if_done=1
if_done      out  1       one-cycle pulse, fetch complete
mem_req      in   1       MEM request; held until mem_done
mem_we       in   1       1=store, 0=load
mem_len      in   2       access size: 0=1B, 1=2B, 2=4B; 3 is illegal and treated as 4B
mem_addr     in   ADDR_W  byte address
mem_wdata    in   DATA_W  store data; low bytes are used
mem_rdata    out  DATA_W  load data, zero-extended; valid when mem_done=1
mem_done     out  1       one-cycle pulse, access complete
ram_a        out  ADDR_W  RAM byte address
ram_dout     out  8       RAM write byte
ram_wr       out  1       RAM write enable
ram_din      in   8       RAM read byte; RAM registers the address, so this is one-cycle read latency

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - All outputs 0: if_inst, mem_rdata, ram_a, ram_dout, ram_wr, if_done, mem_done.
  - Byte counter cleared.
  - Reset mid-transaction abandons it silently; no done pulse is issued.
- rdy=0: state, counter, address and data registers hold. ram_wr is forced 0 and done outputs are held at 0. Resumes exactly where it left off.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE arbitration, evaluated at the posedge:
  - mem_req has priority over if_req.
  - if_req is ignored while jump_or_not=1.
  - The winning request's address, len, we and wdata are latched.
  - N = 4 for IF, else the byte count from mem_len.
- No preemption: a granted access runs to completion, except that IF is aborted by flush.
- Timing, with the request sampled at the end of cycle T0:
  - Read: ram_a = base+k in cycle T(k+1) for k=0..N-1, with ram_wr=0. Byte k is captured from ram_din at the end of cycle T(k+2) into bits [8k+7:8k]. Upper bytes are 0.
  - Write: in cycle T(k+1), ram_a = base+k, ram_dout = wdata[8k+7:8k] and ram_wr=1. ram_wr=0 in every other cycle.
  - Done: the done pulse and data are valid in cycle T(N+2), the DONE state, for both reads and writes. 4-byte latency is 6 cycles; 1-byte latency is 3 cycles.
- DONE lasts exactly one cycle, then the block returns to IDLE. Requests are not sampled in DONE; requesters drop req in the cycle after done.
- Data holding:
  - if_inst holds its value until the next if_done.
  - mem_rdata holds its value until the next load done.
  - A store does not alter mem_rdata.
- Flush (jump_or_not=1) in IF_RD:
  - Go to IDLE at the next posedge; no if_done is issued and if_inst is unchanged.
  - The RAM read in flight is discarded.
  - Flush has no effect on MEM_RD or MEM_WR.
- Address arithmetic is base+k mod 2^ADDR_W; wrap at 0xFFFFFFFF is permitted.
- Simultaneous if_req and mem_req in IDLE: MEM is served first. IF is served at the next IDLE sample if it is still requested.

Test Plan:
- IF fetch at 0x100 with RAM bytes 13,05,00,00: if_done only in T6, if_inst=0x00000513, ram_wr=0 throughout.
- MEM store, mem_len=2, addr 0x2000, wdata 0xDEADBEEF: ram_wr=1 in T1..T4 with bytes EF,BE,AD,DE at 0x2000..0x2003; mem_done in T6. A following 2-byte load of 0x2002 returns mem_rdata=0x0000DEAD in T4.
- if_req and mem_req asserted together in T0 (1-byte load at 0x10): mem_done in T3, one DONE cycle, then IF is granted and if_done arrives 6 cycles after the grant sample.
- jump_or_not pulsed in T3 of a fetch: no if_done, IDLE in T4. A new if_req at 0x200 then completes normally with correct data.
- rdy=0 for cycles T2..T4 of a 4-byte store: no ram_wr during the freeze, all 4 bytes are written exactly once, and mem_done is delayed by exactly 3 cycles.
- rst_n=0 in T3 of a load: outputs 0 next cycle, no mem_done. The held mem_req is re-served from IDLE after rst_n=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between instruction fetch and the MEM stage.
// Each 1/2/4-byte access is split into RAM byte cycles; reads are reassembled little-endian.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              jump_or_not,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          cnt_reg;
  logic [2:0]          len_reg;
  logic                src_if_reg;
  logic                fresh_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rbuf_reg, rbuf_next;
  logic [DATA_W-1:0]   if_inst_reg, mem_rdata_reg;
  logic [ADDR_W-1:0]   ram_a_reg;
  logic [7:0]          ram_dout_reg;
  logic                ram_wr_reg;

  logic                reading;
  logic                cap_en;
  logic [1:0]          cap_idx;
  logic                step_last;
  logic                more_bytes;
  logic [2:0]          mem_nbytes;

  assign mem_nbytes = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
  assign reading    = (state_reg == IF_RD) || (state_reg == MEM_RD);
  assign step_last  = (cnt_reg == len_reg);
  assign more_bytes = (3'(cnt_reg + 3'd1) < len_reg);
  assign cap_idx    = 2'(cnt_reg[1:0] - 2'd1);

  // ram_din is only trustworthy in the cycle right after the address advanced; a frozen
  // cycle keeps re-registering the current address, so capture happens once on the
  // first cycle after an advance, even if that cycle is itself frozen.
  assign cap_en = reading && fresh_reg && (cnt_reg != 3'd0);

  always_comb begin
    rbuf_next = rbuf_reg;
    if (cap_en) begin
      rbuf_next[{cap_idx, 3'b000} +: 8] = ram_din;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (rdy) begin
      case (state_reg)
        IDLE: begin
          if (mem_req) begin
            state_next = mem_we ? MEM_WR : MEM_RD;
          end else if (if_req && !jump_or_not) begin
            state_next = IF_RD;
          end
        end
        IF_RD: begin
          if (jump_or_not) begin
            state_next = IDLE;
          end else if (step_last) begin
            state_next = DONE;
          end
        end
        MEM_RD, MEM_WR: begin
          if (step_last) begin
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      len_reg       <= 3'd0;
      src_if_reg    <= 1'b0;
      fresh_reg     <= 1'b0;
      wdata_reg     <= '0;
      rbuf_reg      <= '0;
      if_inst_reg   <= '0;
      mem_rdata_reg <= '0;
      ram_a_reg     <= '0;
      ram_dout_reg  <= 8'd0;
      ram_wr_reg    <= 1'b0;
    end else begin
      fresh_reg <= rdy;
      if (cap_en) begin
        rbuf_reg <= rbuf_next;
      end
      if (rdy) begin
        state_reg <= state_next;
        case (state_reg)
          IDLE: begin
            if (state_next != IDLE) begin
              cnt_reg      <= 3'd0;
              rbuf_reg     <= '0;
              src_if_reg   <= (state_next == IF_RD);
              len_reg      <= mem_req ? mem_nbytes : 3'd4;
              ram_a_reg    <= mem_req ? mem_addr : if_addr;
              ram_dout_reg <= mem_wdata[7:0];
              wdata_reg    <= mem_wdata >> 8;
              ram_wr_reg   <= (state_next == MEM_WR);
            end
          end
          IF_RD, MEM_RD, MEM_WR: begin
            if (state_next != IDLE) begin
              cnt_reg <= 3'(cnt_reg + 3'd1);
              if (more_bytes) begin
                ram_a_reg    <= ram_a_reg + ADDR_W'(1);
                ram_dout_reg <= wdata_reg[7:0];
                wdata_reg    <= wdata_reg >> 8;
                ram_wr_reg   <= (state_reg == MEM_WR);
              end else begin
                ram_wr_reg <= 1'b0;
              end
              if (step_last && state_reg == IF_RD) begin
                if_inst_reg <= rbuf_next;
              end
              if (step_last && state_reg == MEM_RD) begin
                mem_rdata_reg <= rbuf_next;
              end
            end else begin
              ram_wr_reg <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign if_done   = rdy && (state_reg == DONE) && src_if_reg;
  assign mem_done  = rdy && (state_reg == DONE) && !src_if_reg;
  assign if_inst   = if_inst_reg;
  assign mem_rdata = mem_rdata_reg;
  assign ram_a     = ram_a_reg;
  assign ram_dout  = ram_dout_reg;
  assign ram_wr    = ram_wr_reg && rdy;

endmodule
